jogador_automatico: RTL

- Automatic player that sits on the player side of the memory-game controller, driving the button inputs where a human would.
- Observes the LED exhibition phase, records each displayed LED pattern into an internal buffer, then replays the recorded sequence as button presses during the play phase.
- Used for self-test and demo of the full game loop (exhibition -> plays -> next sequence) without human input.

---
 rtl/jogador_automatico.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: records the LED patterns shown during exhibition
// and replays them as button presses, handshaking on estado_espera.
module jogador_automatico #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned PRESS_MIN = 4,
    parameter int unsigned PRESS_MAX = 1000,
    parameter int unsigned GAP       = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   habilita,
    input  logic [WIDTH-1:0]       leds,
    input  logic                   macro_exibicao,
    input  logic                   estado_ledsOn,
    input  logic                   estado_espera,
    input  logic                   pronto,
    output logic [WIDTH-1:0]       botoes,
    output logic                   jogando,
    output logic [$clog2(DEPTH):0] capturados,
    output logic                   overflow,
    output logic                   erro_bot,
    output logic [3:0]             db_estado
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(PRESS_MAX) + 1;

    localparam logic [CW-1:0] DepthC    = CW'(DEPTH);
    localparam logic [TW-1:0] GapC      = TW'(GAP);
    localparam logic [TW-1:0] PressMinC = TW'(PRESS_MIN - 1);
    localparam logic [TW-1:0] PressMaxC = TW'(PRESS_MAX - 1);

    typedef enum logic [3:0] {
        Idle      = 4'd0,
        Captura   = 4'd1,
        Aguarda   = 4'd2,
        Pressiona = 4'd3,
        Solta     = 4'd4,
        Fim       = 4'd5
    } estadoT;

    estadoT           estado;
    logic             macroAnt;
    logic             ledsOnAnt;
    logic [CW-1:0]    ponteiro;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] memoria [DEPTH];

    logic macroSobe;
    logic ledsOnSobe;
    logic grava;

    always_comb begin
        macroSobe  = macro_exibicao & ~macroAnt;
        ledsOnSobe = estado_ledsOn & ~ledsOnAnt;
        // Same gating as the FSM's Captura branch, so buffer and counter stay in step
        grava      = habilita && !pronto && !macroSobe && (estado == Captura) &&
                     ledsOnSobe && (leds != '0) && (capturados < DepthC);
    end

    always_ff @(posedge clock) begin
        if (grava) begin
            memoria[capturados[AW-1:0]] <= leds;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= Idle;
            botoes     <= '0;
            capturados <= '0;
            overflow   <= 1'b0;
            erro_bot   <= 1'b0;
            ponteiro   <= '0;
            timer      <= '0;
            macroAnt   <= 1'b0;
            ledsOnAnt  <= 1'b0;
        end else begin
            macroAnt  <= macro_exibicao;
            ledsOnAnt <= estado_ledsOn;
            // Buttons follow the current state, so they lag a transition by one cycle
            if (estado == Pressiona) begin
                botoes <= memoria[ponteiro[AW-1:0]];
            end else begin
                botoes <= '0;
            end

            if (!habilita || pronto) begin
                estado <= Idle;
            end else if (macroSobe) begin
                estado     <= Captura;
                capturados <= '0;
                overflow   <= 1'b0;
                ponteiro   <= '0;
                erro_bot   <= 1'b0;
            end else begin
                case (estado)
                    Idle: ;
                    Captura: begin
                        if (grava) begin
                            capturados <= capturados + 1'b1;
                        end else if (ledsOnSobe && (leds != '0)) begin
                            overflow <= 1'b1;
                        end
                        if (!macro_exibicao && estado_espera) begin
                            estado   <= Aguarda;
                            timer    <= '0;
                            ponteiro <= '0;
                        end
                    end
                    Aguarda: begin
                        // Saturate: only the threshold matters while the game is busy
                        if (timer < GapC) begin
                            timer <= timer + 1'b1;
                        end
                        if (ponteiro == capturados) begin
                            estado <= Fim;
                        end else if ((timer >= GapC) && estado_espera) begin
                            estado <= Pressiona;
                            timer  <= '0;
                        end
                    end
                    Pressiona: begin
                        timer <= timer + 1'b1;
                        if ((timer >= PressMinC) && !estado_espera) begin
                            estado   <= Solta;
                            ponteiro <= ponteiro + 1'b1;
                        end else if (timer == PressMaxC) begin
                            estado   <= Fim;
                            erro_bot <= 1'b1;
                        end
                    end
                    Solta: begin
                        timer  <= '0;
                        estado <= Aguarda;
                    end
                    Fim: ;
                    default: estado <= Idle;
                endcase
            end
        end
    end

    assign jogando   = (estado == Aguarda) || (estado == Pressiona) || (estado == Solta);
    assign db_estado = estado;

endmodule
